// File: rtl/reg_bus_arbiter_if.sv
// Request/grant bundle between the control-unit requesters and the register
// read-bus arbiter that steers the R0-R3 select mux.
interface reg_bus_arbiter_if;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout_err;

  modport master (
    output req, done,
    input  gnt, sel, busy, timeout_err
  );

  modport slave (
    input  req, done,
    output gnt, sel, busy, timeout_err
  );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Round-robin owner of the 8-bit register read bus: one-hot grant, registered
// mux select, and forced release when an owner holds the bus too long.
module reg_bus_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  reg_bus_arbiter_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam bit         TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [7:0] HOLD_LAST  = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [1:0] last_q, last_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] gnt_q, gnt_d;
  logic       terr_q, terr_d;

  logic       pick_valid;
  logic [1:0] pick_idx;
  logic [1:0] cand;

  // Scan from last+1 upward; iterating from the far end lets the nearest
  // requester overwrite any earlier hit.
  always_comb begin : rr_pick
    pick_valid = 1'b0;
    pick_idx   = last_q;
    cand       = last_q;
    for (int k = 4; k >= 1; k--) begin
      cand = last_q + 2'(k);
      if (bus.req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // sel_q doubles as the owner index while in OWN.
  always_comb begin : next_state
    // NOTE: every output of this block gets a default first, so no path can leave a latch behind.
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    terr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d   = 4'b0001 << pick_idx;
          sel_d   = pick_idx;
          cnt_d   = 8'd0;
          state_d = OWN;
        end
      end
      OWN: begin
        if (bus.done[sel_q] || !bus.req[sel_q]) begin
          gnt_d   = 4'b0000;
          last_d  = sel_q;
          state_d = IDLE;
        end else if (TIMEOUT_EN && (cnt_q == HOLD_LAST)) begin
          gnt_d   = 4'b0000;
          last_d  = sel_q;
          terr_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 2'd3;
      sel_q   <= 2'd0;
      cnt_q   <= 8'd0;
      gnt_q   <= 4'b0000;
      terr_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking here so every register samples pre-edge values regardless of statement order.
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      terr_q  <= terr_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.sel         = sel_q;
  assign bus.busy        = |gnt_q;
  assign bus.timeout_err = terr_q;

endmodule
